// File: rtl/cpu64_l2_directory.sv
// L2 coherence directory: SETS x WAYS entries of {valid, sharers, owner, dirty}.
// All ways of one set are read combinationally; one entry is written per clock.
module cpu64_l2_directory #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [$clog2(SETS)-1:0]             rd_set_i,
  output logic [WAYS-1:0]                     rd_valid_o,
  output logic [WAYS*CORES-1:0]               rd_sharers_o,
  output logic [WAYS-1:0]                     rd_owner_valid_o,
  output logic [WAYS*$clog2(CORES)-1:0]       rd_owner_id_o,
  output logic [WAYS-1:0]                     rd_dirty_o,
  input  logic                                we_i,
  input  logic [$clog2(SETS)-1:0]             wr_set_i,
  input  logic [$clog2(WAYS)-1:0]             wr_way_i,
  input  logic                                wr_valid_i,
  input  logic [CORES-1:0]                    wr_sharers_i,
  input  logic                                wr_owner_valid_i,
  input  logic [$clog2(CORES)-1:0]            wr_owner_id_i,
  input  logic                                wr_dirty_i
);

  localparam int IDW     = $clog2(CORES);
  localparam int DIRTY_B = 0;
  localparam int ID_LSB  = 1;
  localparam int OV_B    = 1 + IDW;
  localparam int SH_LSB  = 2 + IDW;
  localparam int V_B     = 2 + IDW + CORES;
  localparam int EW      = 3 + IDW + CORES;

  // Flop-based storage: reset must clear every entry asynchronously and reads
  // cover a whole set with no latency, so a block RAM cannot be used here.
  logic [EW-1:0] mem_q [SETS][WAYS];

  logic          wr_ov;
  logic [EW-1:0] wr_entry_d;

  // Dirty implies owned, and an owned line has no sharers; an invalid write
  // stores all zeros so the invariants hold for every stored entry.
  assign wr_ov      = wr_owner_valid_i | wr_dirty_i;
  assign wr_entry_d = wr_valid_i
                    ? {1'b1, (wr_ov ? {CORES{1'b0}} : wr_sharers_i),
                       wr_ov, wr_owner_id_i, wr_dirty_i}
                    : {EW{1'b0}};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wr_set_i][wr_way_i] <= wr_entry_d;
    end
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_rd
    logic [EW-1:0] ent;
    assign ent                            = mem_q[rd_set_i][gi];
    assign rd_valid_o[gi]                 = ent[V_B];
    assign rd_sharers_o[gi*CORES +: CORES] = ent[SH_LSB +: CORES];
    assign rd_owner_valid_o[gi]           = ent[OV_B];
    assign rd_owner_id_o[gi*IDW +: IDW]   = ent[ID_LSB +: IDW];
    assign rd_dirty_o[gi]                 = ent[DIRTY_B];
  end

endmodule

// File: tb/tb_cpu64_l2_directory.sv
// Directed checks for cpu64_l2_directory with default parameters.
module tb_cpu64_l2_directory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_set_i = '0;
  logic [15:0] rd_valid_o;
  logic [63:0] rd_sharers_o;
  logic [15:0] rd_owner_valid_o;
  logic [31:0] rd_owner_id_o;
  logic [15:0] rd_dirty_o;
  logic        we_i = 1'b0;
  logic [7:0]  wr_set_i = '0;
  logic [3:0]  wr_way_i = '0;
  logic        wr_valid_i = 1'b0;
  logic [3:0]  wr_sharers_i = '0;
  logic        wr_owner_valid_i = 1'b0;
  logic [1:0]  wr_owner_id_i = '0;
  logic        wr_dirty_i = 1'b0;

  int total = 0;
  int bad   = 0;

  cpu64_l2_directory dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_set_i         (rd_set_i),
    .rd_valid_o       (rd_valid_o),
    .rd_sharers_o     (rd_sharers_o),
    .rd_owner_valid_o (rd_owner_valid_o),
    .rd_owner_id_o    (rd_owner_id_o),
    .rd_dirty_o       (rd_dirty_o),
    .we_i             (we_i),
    .wr_set_i         (wr_set_i),
    .wr_way_i         (wr_way_i),
    .wr_valid_i       (wr_valid_i),
    .wr_sharers_i     (wr_sharers_i),
    .wr_owner_valid_i (wr_owner_valid_i),
    .wr_owner_id_i    (wr_owner_id_i),
    .wr_dirty_i       (wr_dirty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Read one set and compare all five outputs.
  task automatic chk_set(input string tag, input logic [7:0] set,
                         input logic [15:0] v, input logic [63:0] sh,
                         input logic [15:0] ov, input logic [31:0] id,
                         input logic [15:0] d);
    rd_set_i = set;
    #1;
    chk({tag, ".valid"},   {48'd0, rd_valid_o}, {48'd0, v});
    chk({tag, ".sharers"}, rd_sharers_o, sh);
    chk({tag, ".ownv"},    {48'd0, rd_owner_valid_o}, {48'd0, ov});
    chk({tag, ".ownid"},   {32'd0, rd_owner_id_o}, {32'd0, id});
    chk({tag, ".dirty"},   {48'd0, rd_dirty_o}, {48'd0, d});
    $display("read %s set=%0d valid=%h sharers=%h ownv=%h id=%h dirty=%h",
             tag, set, rd_valid_o, rd_sharers_o, rd_owner_valid_o, rd_owner_id_o, rd_dirty_o);
  endtask

  task automatic wr(input logic en, input logic [7:0] set, input logic [3:0] way,
                    input logic v, input logic [3:0] sh, input logic ov,
                    input logic [1:0] id, input logic d);
    @(negedge clk);
    we_i = en; wr_set_i = set; wr_way_i = way; wr_valid_i = v;
    wr_sharers_i = sh; wr_owner_valid_i = ov; wr_owner_id_i = id; wr_dirty_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0;
    $display("write we=%0b set=%0d way=%0d v=%0b sh=%b ov=%0b id=%0d d=%0b",
             en, set, way, v, sh, ov, id, d);
  endtask

  initial begin
    #1 rst_n = 1'b1;
    #12;
    chk_set("rst0", 8'd0, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);
    chk_set("rst10", 8'd10, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;

    // Same-set read during the write: old contents before the edge, new after.
    rd_set_i = 8'd10;
    @(negedge clk);
    we_i = 1'b1; wr_set_i = 8'd10; wr_way_i = 4'd5; wr_valid_i = 1'b1;
    wr_sharers_i = 4'b1010; wr_owner_valid_i = 1'b0; wr_owner_id_i = 2'd0; wr_dirty_i = 1'b0;
    #3;
    chk("prewrite.valid", {48'd0, rd_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    we_i = 1'b0;
    $display("write we=1 set=10 way=5 v=1 sh=1010 ov=0 id=0 d=0");
    chk_set("s10w5", 8'd10, 16'h0020, 64'h0000_0000_00A0_0000, 16'h0, 32'h0, 16'h0);

    wr(1'b1, 8'd20, 4'd2, 1'b1, 4'b1111, 1'b1, 2'd2, 1'b0);
    chk_set("s20w2", 8'd20, 16'h0004, 64'h0, 16'h0004, 32'h0000_0020, 16'h0);

    wr(1'b1, 8'd30, 4'd0, 1'b1, 4'b0101, 1'b0, 2'd3, 1'b1);
    chk_set("s30w0", 8'd30, 16'h0001, 64'h0, 16'h0001, 32'h0000_0003, 16'h0001);

    wr(1'b0, 8'd40, 4'd1, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b1);
    chk_set("noen", 8'd40, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);

    wr(1'b1, 8'd255, 4'd15, 1'b1, 4'b0011, 1'b0, 2'd1, 1'b0);
    chk_set("s255w15", 8'd255, 16'h8000, 64'h3000_0000_0000_0000, 16'h0, 32'h4000_0000, 16'h0);

    wr(1'b1, 8'd20, 4'd15, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
    chk_set("s20both", 8'd20, 16'h8004, 64'h6000_0000_0000_0000, 16'h0004, 32'h0000_0020, 16'h0);

    wr(1'b1, 8'd10, 4'd5, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1);
    chk_set("inval10", 8'd10, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);
    chk_set("keep30", 8'd30, 16'h0001, 64'h0, 16'h0001, 32'h0000_0003, 16'h0001);

    // Mid-run reset: asynchronous clear, and a write held across it is blocked.
    @(negedge clk);
    we_i = 1'b1; wr_set_i = 8'd20; wr_way_i = 4'd3; wr_valid_i = 1'b1;
    wr_sharers_i = 4'b0001; wr_owner_valid_i = 1'b0; wr_owner_id_i = 2'd0; wr_dirty_i = 1'b0;
    rd_set_i = 8'd20;
    #1 rst_n = 1'b1;
    #1;
    chk("asyncrst.valid", {48'd0, rd_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    we_i = 1'b0;
    rst_n = 1'b0;
    $display("reset pulse with pending write set=20 way=3");
    chk_set("post20", 8'd20, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);
    chk_set("post30", 8'd30, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);
    chk_set("post255", 8'd255, 16'h0, 64'h0, 16'h0, 32'h0, 16'h0);

    wr(1'b1, 8'd1, 4'd1, 1'b1, 4'b1001, 1'b0, 2'd2, 1'b0);
    chk_set("resume", 8'd1, 16'h0002, 64'h0000_0000_0000_0090, 16'h0, 32'h0000_0008, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu64_l2_directory.md
CPU64_L2_DIRECTORY -- requirements
Module: cpu64_l2_directory

Interface
REQ-001 SHALL provide parameter SETS, default 256, number of directory sets (power of two).
REQ-002 SHALL provide parameter WAYS, default 16, ways per set (power of two).
REQ-003 SHALL provide parameter CORES, default 4, number of tracked cores (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all writes occur on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous reset, active-high (asserted when 1).
REQ-006 SHALL have port rd_set_i  input  clog2(SETS)  read set index.
REQ-007 SHALL have port rd_valid_o  output  WAYS  valid bit per way; bit w = way w.
REQ-008 SHALL have port rd_sharers_o  output  WAYS*CORES  sharer vectors; way w at [w*CORES +: CORES], bit c = core c.
REQ-009 SHALL have port rd_owner_valid_o  output  WAYS  owner-present bit per way.
REQ-010 SHALL have port rd_owner_id_o  output  WAYS*clog2(CORES)  owner id; way w at [w*clog2(CORES) +: clog2(CORES)].
REQ-011 SHALL have port rd_dirty_o  output  WAYS  dirty bit per way.
REQ-012 SHALL have port we_i  input  1  write enable for one way entry.
REQ-013 SHALL have port wr_set_i  input  clog2(SETS)  write set index.
REQ-014 SHALL have port wr_way_i  input  clog2(WAYS)  write way index.
REQ-015 SHALL have ports wr_valid_i (1), wr_sharers_i (CORES), wr_owner_valid_i (1), wr_owner_id_i (clog2(CORES)), wr_dirty_i (1), all inputs: entry fields to write.

Function
REQ-016 SHALL store SETS x WAYS entries, each {valid, sharers[CORES], owner_valid, owner_id, dirty}.
REQ-017 SHALL read combinationally: all outputs reflect every way of set rd_set_i in the same cycle, with no clock latency.
REQ-018 SHALL, on a rising clk edge with we_i=1 and reset deasserted, update only entry (wr_set_i, wr_way_i); all other ways and sets keep their values.
REQ-019 SHALL compute stored fields from the inputs as follows: dirty = wr_dirty_i; owner_valid = wr_owner_valid_i OR wr_dirty_i; owner_id = wr_owner_id_i; sharers = 0 if owner_valid (after forcing) else wr_sharers_i.
REQ-020 SHALL, when wr_valid_i=0, store an all-zero entry, ignoring the other write fields.
REQ-021 SHALL, for a same-set read during a write cycle, present the pre-write contents until the edge and the new contents immediately after it, with no bypass.
REQ-022 SHALL ignore all write fields when we_i=0.
REQ-023 SHALL ensure that invariants owner_valid => sharers==0 and dirty => owner_valid hold for every stored entry at all times.

Reset
REQ-024 SHALL, while rst_n=1, asynchronously clear every field of every entry to 0, so all outputs read 0 for any rd_set_i.
REQ-025 SHALL block writes while rst_n=1, including a write coinciding with reset assertion; operation resumes on the first rising edge after deassertion.

Verification
REQ-026 SHALL pass: reset, then read any set -> all outputs 0.
REQ-027 SHALL pass: write set10/way5 valid=1 sharers=1010 owner_valid=0 dirty=0; next cycle rd_set_i=10 -> rd_valid_o[5]=1, rd_sharers_o[23:20]=1010, other ways 0.
REQ-028 SHALL pass: write set20/way2 valid=1 sharers=1111 owner_valid=1 id=2 -> rd_owner_valid_o[2]=1, owner id 2, sharers[11:8]=0000.
REQ-029 SHALL pass: write set30/way0 valid=1 owner_valid=0 id=3 dirty=1 -> rd_dirty_o[0]=1, rd_owner_valid_o[0]=1, owner id 3.
REQ-030 SHALL pass: write set10/way5 with wr_valid_i=0 -> way5 reads all-zero, while set20/way2 and set30/way0 are unchanged.
REQ-031 SHALL pass: assert rst_n mid-run, then deassert -> all previously written entries read 0.
